lsu_stage: RTL and testbench

LSU_STAGE -- requirements
Module: lsu_stage

---
 rtl/lsu_stage.sv | 206 ++++++++++++++++++++
 tb/tb_lsu_stage.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
// lsu_stage: RV32I load/store stage between execute and writeback.
// Three-state FSM (IDLE/REQ/WAIT) drives a req/gnt + rvalid data-memory port.
// Non-memory and illegal ops complete in one cycle at full throughput.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently truncating the address to natural alignment.

// One byte lane of the store path: strobe and replicated write byte.
module lsu_lane #(
    parameter int VEC_W = 8,
    parameter int LANE  = 0
) (
    input  logic [1:0]       size,
    input  logic [1:0]       lsb,
    input  logic [VEC_W-1:0] byte_src,
    input  logic [VEC_W-1:0] half_src,
    input  logic [VEC_W-1:0] word_src,
    output logic             stb,
    output logic [VEC_W-1:0] wbyte
);
    localparam logic [1:0] LID = 2'(LANE);

    // select lane enable and data by access size
    always_comb begin
        stb   = 1'b1;
        wbyte = word_src;
        case (size)
            2'b00: begin
                stb   = (lsb == LID);
                wbyte = byte_src;
            end
            2'b01: begin
                stb   = (lsb[1] == LID[1]);
                wbyte = half_src;
            end
            default: begin
                stb   = 1'b1;
                wbyte = word_src;
            end
        endcase
    end
endmodule

module lsu_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_store_data,
    input  logic [2:0]  in_funct3,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        misalign_trap
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    // context of the memory op in flight
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw;
        logic        store;
    } pend_t;

    state_t state;
    pend_t  pend;

    logic [1:0] lsb, size;
    logic       mem_op, ld_ok, st_ok, misalign, go_mem;
    logic [NUM_LANES-1:0]            lane_stb;
    logic [NUM_LANES-1:0][VEC_W-1:0] lane_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign in_ready = (state == IDLE);

    // decode legality and alignment of the incoming op
    always_comb begin
        lsb    = in_addr[1:0];
        size   = in_funct3[1:0];
        mem_op = in_mem_read || in_mem_write;
        ld_ok  = in_mem_read && !in_mem_write &&
                 (in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        st_ok  = in_mem_write && !in_mem_read && (in_funct3 <= 3'b010);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = (ld_ok || st_ok) &&
                   ((size == 2'b01 && lsb[0]) || (size == 2'b10 && lsb != 2'b00));
`else
        // low address bits beyond natural alignment are simply ignored
        misalign = 1'b0;
`endif
        go_mem = (ld_ok || st_ok) && !misalign;
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lsu_lane #(.VEC_W(VEC_W), .LANE(g)) u_lane (
            .size     (size),
            .lsb      (lsb),
            .byte_src (in_store_data[VEC_W-1:0]),
            .half_src (in_store_data[VEC_W*(g%2) +: VEC_W]),
            .word_src (in_store_data[VEC_W*g +: VEC_W]),
            .stb      (lane_stb[g]),
            .wbyte    (lane_wdata[g])
        );
    end

    // extract and extend the loaded lane from the returned word
    always_comb begin
        ld_byte = dmem_rdata[{pend.addr[1:0], 3'b000} +: 8];
        ld_half = dmem_rdata[{pend.addr[1], 4'b0000} +: 16];
        case (pend.f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    // control FSM with registered memory and writeback outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pend          <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wstrb    <= '0;
            dmem_wdata    <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            wb_data       <= '0;
            misalign_trap <= 1'b0;
        end else begin
            wb_valid      <= 1'b0;
            misalign_trap <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (go_mem) begin
                            state      <= REQ;
                            dmem_req   <= 1'b1;
                            dmem_we    <= st_ok;
                            dmem_addr  <= {in_addr[31:2], 2'b00};
                            dmem_wstrb <= st_ok ? lane_stb : 4'b0000;
                            dmem_wdata <= lane_wdata;
                            pend       <= '{addr: in_addr, f3: in_funct3, rd: in_rd,
                                            rw: in_reg_write, store: st_ok};
                        end else begin
                            // plain ALU result, illegal op or trapped access
                            wb_valid      <= 1'b1;
                            wb_rd         <= in_rd;
                            wb_reg_write  <= in_reg_write && !mem_op;
                            wb_data       <= in_addr;
                            misalign_trap <= misalign;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (pend.store) begin
                            state        <= IDLE;
                            wb_valid     <= 1'b1;
                            wb_rd        <= pend.rd;
                            wb_reg_write <= 1'b0;
                            wb_data      <= pend.addr;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        state        <= IDLE;
                        wb_valid     <= 1'b1;
                        wb_rd        <= pend.rd;
                        wb_reg_write <= pend.rw;
                        wb_data      <= ld_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: directed table, hand sequences and random ops vs a byte-level model.
module tb_lsu_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_addr, in_store_data;
    logic [2:0]  in_funct3;
    logic        in_mem_read, in_mem_write;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        misalign_trap;

    int tests = 0;
    int fails = 0;

    lsu_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_store_data(in_store_data), .in_funct3(in_funct3),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_rd(in_rd), .in_reg_write(in_reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_data(wb_data), .misalign_trap(misalign_trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mr, mw;
        logic [2:0]  f3;
        logic [31:0] addr, sd, rdata;
        logic [4:0]  rd;
        logic        rw;
        int          gd, rvd;
    } op_t;

    typedef struct {
        logic        req, we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] mwdata;
        logic        wre, trap, chk;
        logic [31:0] wbd;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t e;
    } rec_t;

    rec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic op_t mk_op(logic mr, logic mw, logic [2:0] f3, logic [31:0] addr,
                                  logic [31:0] sd, logic [4:0] rd, logic rw,
                                  logic [31:0] rdata, int gd, int rvd);
        op_t o;
        o.mr = mr; o.mw = mw; o.f3 = f3; o.addr = addr; o.sd = sd;
        o.rd = rd; o.rw = rw; o.rdata = rdata; o.gd = gd; o.rvd = rvd;
        return o;
    endfunction

    function automatic exp_t mk_exp(logic req, logic we, logic [31:0] addr, logic [3:0] wstrb,
                                    logic [31:0] mwdata, logic wre, logic trap, logic c,
                                    logic [31:0] wbd);
        exp_t e;
        e.req = req; e.we = we; e.addr = addr; e.wstrb = wstrb; e.mwdata = mwdata;
        e.wre = wre; e.trap = trap; e.chk = c; e.wbd = wbd;
        return e;
    endfunction

    function automatic void add(op_t o, exp_t e);
        rec_t r;
        r.op = o;
        r.e  = e;
        tbl.push_back(r);
    endfunction

    // Reference: access of n bytes at offset off inside the word; stores
    // repeat the n source bytes across the word, loads shift/mask/extend.
    function automatic exp_t model(op_t o);
        exp_t e;
        int n, off;
        logic ld, st, mis;
        logic [31:0] v, m;
        e = mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ld = o.mr && !o.mw && !(o.f3 == 3 || o.f3 == 6 || o.f3 == 7);
        st = o.mw && !o.mr && (o.f3 <= 2);
        n = 1 << o.f3[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (ld || st) && ((o.addr % n) != 0);
`else
        mis = 1'b0;
`endif
        if (!(ld || st) || mis) begin
            e.wre  = !(o.mr || o.mw) && o.rw;
            e.trap = mis;
            e.chk  = !mis;
            e.wbd  = o.addr;
            return e;
        end
        off    = int'(o.addr % 4) / n * n;
        e.req  = 1'b1;
        e.we   = st;
        e.addr = o.addr & ~32'h3;
        if (st) begin
            e.wstrb = 4'(((1 << n) - 1) << off);
            for (int k = 0; k < 4; k++) e.mwdata[8*k +: 8] = o.sd[8*(k % n) +: 8];
        end else begin
            v = o.rdata >> (8 * off);
            if (n < 4) begin
                m = (32'h1 << (8 * n)) - 32'h1;
                v = v & m;
                if (o.f3[2] == 1'b0 && v[8*n-1]) v = v | ~m;
            end
            e.wre = o.rw;
            e.chk = 1'b1;
            e.wbd = v;
        end
        return e;
    endfunction

    task automatic clear_inputs;
        in_valid = 0; in_addr = 0; in_store_data = 0; in_funct3 = 0;
        in_mem_read = 0; in_mem_write = 0; in_rd = 0; in_reg_write = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic drive_op(input op_t o);
        in_valid = 1; in_mem_read = o.mr; in_mem_write = o.mw; in_funct3 = o.f3;
        in_addr = o.addr; in_store_data = o.sd; in_rd = o.rd; in_reg_write = o.rw;
    endtask

    // apply one op with its memory handshake and check every visible output
    task automatic run_op(input op_t o, input exp_t e, input string tag);
        chk($sformatf("%s.in_ready_idle", tag), in_ready, 1);
        drive_op(o);
        tick;
        in_valid = 0; in_mem_read = 0; in_mem_write = 0;
        if (e.req) begin
            for (int i = 0; i <= o.gd; i++) begin
                chk($sformatf("%s.req", tag), dmem_req, 1);
                chk($sformatf("%s.we", tag), dmem_we, e.we);
                chk($sformatf("%s.addr", tag), dmem_addr, e.addr);
                chk($sformatf("%s.wstrb", tag), dmem_wstrb, e.wstrb);
                if (e.we) chk($sformatf("%s.wdata", tag), dmem_wdata, e.mwdata);
                chk($sformatf("%s.busy", tag), in_ready, 0);
                dmem_gnt = (i == o.gd);
                tick;
            end
            dmem_gnt = 0;
            chk($sformatf("%s.req_drop", tag), dmem_req, 0);
            if (!e.we) begin
                for (int j = 0; j < o.rvd; j++) begin
                    chk($sformatf("%s.wb_early", tag), wb_valid, 0);
                    tick;
                end
                dmem_rvalid = 1;
                dmem_rdata  = o.rdata;
                tick;
                dmem_rvalid = 0;
                dmem_rdata  = $urandom;
            end
        end
        chk($sformatf("%s.wb_valid", tag), wb_valid, 1);
        chk($sformatf("%s.wb_rd", tag), wb_rd, o.rd);
        chk($sformatf("%s.wb_reg_write", tag), wb_reg_write, e.wre);
        chk($sformatf("%s.trap", tag), misalign_trap, e.trap);
        chk($sformatf("%s.ready_at_wb", tag), in_ready, 1);
        chk($sformatf("%s.no_req_at_wb", tag), dmem_req, 0);
        if (e.chk) chk($sformatf("%s.wb_data", tag), wb_data, e.wbd);
        tick;
        chk($sformatf("%s.wb_pulse", tag), wb_valid, 0);
        chk($sformatf("%s.trap_pulse", tag), misalign_trap, 0);
    endtask

    initial begin
        op_t o;
        exp_t e;
        logic [31:0] bb_addr [3];

        // directed table
        add(mk_op(0,0,3'b000,32'h12345678,0,5,1,0,0,0), mk_exp(0,0,0,0,0,1,0,1,32'h12345678));
        add(mk_op(0,1,3'b000,32'h00000103,32'hAABBCCDD,7,1,0,3,0), mk_exp(1,1,32'h100,4'b1000,32'hDDDDDDDD,0,0,0,0));
        add(mk_op(1,0,3'b000,32'h00000102,0,9,1,32'h00800000,0,0), mk_exp(1,0,32'h100,0,0,1,0,1,32'hFFFFFF80));
        add(mk_op(1,0,3'b101,32'h00000102,0,10,1,32'h80010000,1,2), mk_exp(1,0,32'h100,0,0,1,0,1,32'h00008001));
        add(mk_op(0,1,3'b001,32'h00000102,32'h11223344,2,1,0,0,0), mk_exp(1,1,32'h100,4'b1100,32'h33443344,0,0,0,0));
        add(mk_op(0,1,3'b010,32'h00000200,32'hCAFEF00D,3,0,0,2,0), mk_exp(1,1,32'h200,4'b1111,32'hCAFEF00D,0,0,0,0));
        add(mk_op(1,0,3'b010,32'h00000204,0,31,1,32'hDEADBEEF,0,3), mk_exp(1,0,32'h204,0,0,1,0,1,32'hDEADBEEF));
        add(mk_op(1,0,3'b100,32'h00000301,0,12,1,32'h0000FF00,1,1), mk_exp(1,0,32'h300,0,0,1,0,1,32'h000000FF));
        add(mk_op(1,0,3'b001,32'h00000300,0,13,1,32'h00008001,0,0), mk_exp(1,0,32'h300,0,0,1,0,1,32'hFFFF8001));
        add(mk_op(1,0,3'b011,32'h00000055,0,3,1,0,0,0), mk_exp(0,0,0,0,0,0,0,1,32'h55));
        add(mk_op(0,1,3'b100,32'h00000066,32'h1,4,1,0,0,0), mk_exp(0,0,0,0,0,0,0,1,32'h66));
        add(mk_op(1,1,3'b010,32'h00000080,32'h2,6,1,0,0,0), mk_exp(0,0,0,0,0,0,0,1,32'h80));
        add(mk_op(0,1,3'b000,32'h00000101,32'h000000A5,8,1,0,1,0), mk_exp(1,1,32'h100,4'b0010,32'hA5A5A5A5,0,0,0,0));
        add(mk_op(1,0,3'b000,32'h00000003,0,14,0,32'h7F000000,0,1), mk_exp(1,0,32'h0,0,0,0,0,1,32'h0000007F));

        // reset values
        clear_inputs();
        rst_n = 0;
        #3;
        chk("rst.dmem_req", dmem_req, 0);
        chk("rst.dmem_we", dmem_we, 0);
        chk("rst.dmem_wstrb", dmem_wstrb, 0);
        chk("rst.dmem_addr", dmem_addr, 0);
        chk("rst.dmem_wdata", dmem_wdata, 0);
        chk("rst.wb_valid", wb_valid, 0);
        chk("rst.wb_reg_write", wb_reg_write, 0);
        chk("rst.wb_data", wb_data, 0);
        chk("rst.wb_rd", wb_rd, 0);
        chk("rst.trap", misalign_trap, 0);
        #19 rst_n = 1;
        tick;
        chk("rst.in_ready", in_ready, 1);

        foreach (tbl[i]) run_op(tbl[i].op, tbl[i].e, $sformatf("tbl%0d", i));

        // three back-to-back ALU results
        bb_addr[0] = 32'h11111111; bb_addr[1] = 32'h22222222; bb_addr[2] = 32'h33333333;
        for (int k = 0; k < 3; k++) begin
            drive_op(mk_op(0,0,0,bb_addr[k],0,5'(k+1),1,0,0,0));
            tick;
            chk($sformatf("b2b%0d.wb_valid", k), wb_valid, 1);
            chk($sformatf("b2b%0d.wb_data", k), wb_data, bb_addr[k]);
            chk($sformatf("b2b%0d.wb_rd", k), wb_rd, k + 1);
        end
        clear_inputs();
        tick;
        chk("b2b.end_pulse", wb_valid, 0);

        // rvalid outside WAIT is ignored
        dmem_rvalid = 1; dmem_rdata = 32'h5555AAAA;
        tick;
        dmem_rvalid = 0;
        chk("rv_idle.wb_valid", wb_valid, 0);
        drive_op(mk_op(1,0,3'b010,32'h40,0,6,1,0,0,0));
        tick;
        clear_inputs();
        dmem_rvalid = 1; dmem_rdata = 32'h5555AAAA;
        tick;
        dmem_rvalid = 0;
        chk("rv_req.still_req", dmem_req, 1);
        chk("rv_req.wb_valid", wb_valid, 0);
        dmem_gnt = 1;
        tick;
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h00001234;
        tick;
        dmem_rvalid = 0;
        chk("rv_wait.wb_valid", wb_valid, 1);
        chk("rv_wait.wb_data", wb_data, 32'h00001234);
        tick;

        // reset while a request is outstanding
        drive_op(mk_op(1,0,3'b010,32'h80,0,7,1,0,0,0));
        tick;
        clear_inputs();
        chk("rst_req.pre", dmem_req, 1);
        rst_n = 0;
        #1;
        chk("rst_req.req_drop", dmem_req, 0);
        #2 rst_n = 1;
        tick;
        chk("rst_req.wb_valid", wb_valid, 0);
        chk("rst_req.req", dmem_req, 0);
        chk("rst_req.in_ready", in_ready, 1);

        // reset while waiting for read data; late rvalid must not write back
        drive_op(mk_op(1,0,3'b010,32'h84,0,8,1,0,0,0));
        tick;
        clear_inputs();
        dmem_gnt = 1;
        tick;
        dmem_gnt = 0;
        rst_n = 0;
        #1;
        chk("rst_wait.req", dmem_req, 0);
        #2 rst_n = 1;
        tick;
        dmem_rvalid = 1; dmem_rdata = 32'hFEEDFACE;
        tick;
        dmem_rvalid = 0;
        chk("rst_wait.late_rv", wb_valid, 0);
        chk("rst_wait.in_ready", in_ready, 1);
        tick;
        chk("rst_wait.late_rv2", wb_valid, 0);

        // misaligned half and word accesses
`ifdef LSU_MISALIGN_TRAP_EN
        run_op(mk_op(1,0,3'b001,32'h101,0,4,1,32'hAAAA8001,0,0), mk_exp(0,0,0,0,0,0,1,0,0), "mis_lh");
        run_op(mk_op(0,1,3'b010,32'h106,32'h12345678,4,1,0,0,0), mk_exp(0,0,0,0,0,0,1,0,0), "mis_sw");
`else
        run_op(mk_op(1,0,3'b001,32'h101,0,4,1,32'hAAAA8001,0,0), mk_exp(1,0,32'h100,0,0,1,0,1,32'hFFFF8001), "mis_lh");
        run_op(mk_op(1,0,3'b010,32'h106,0,4,1,32'h0BADF00D,1,0), mk_exp(1,0,32'h104,0,0,1,0,1,32'h0BADF00D), "mis_lw");
`endif

        // random ops against the reference model
        for (int r = 0; r < 300; r++) begin
            int sel;
            sel = $urandom_range(0, 9);
            o = mk_op(sel >= 3 && sel <= 5 || sel == 9, sel >= 6, 3'($urandom_range(0, 7)),
                      $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3));
            e = model(o);
            run_op(o, e, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
